// File: rtl/gpio_pkg.sv
// -----------------------------------------------------------------------------
// gpio_pkg
// Shared definitions for the GPIO input path: default channel counts, the
// default debounce length, and the register offsets that the GPIO memory
// block decodes for the conditioned inputs.
// -----------------------------------------------------------------------------
package gpio_pkg;

   localparam int NUM_BUTTONS_DEF     = 4;
   localparam int NUM_SWITCHES_DEF    = 16;
   localparam int DEBOUNCE_CYCLES_DEF = 100;

   // Byte offsets inside the GPIO-mapped memory window.
   localparam logic [7:0] GPIO_CLEAN_OFFSET   = 8'h00;  // {switches_clean, buttons_clean}
   localparam logic [7:0] GPIO_LATCHED_OFFSET = 8'h04;  // press_latched, read-only view
   localparam logic [7:0] GPIO_CLEAR_OFFSET   = 8'h08;  // write-one-to-clear of press_latched

   // Width of a debounce counter able to hold 0..cycles.
   function automatic int debounce_cnt_width(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/debounce_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
// Single-bit input conditioner: two-flop synchronizer followed by a
// stability counter. A new level is accepted only after the synchronized
// input has differed from the current clean level for DEBOUNCE_CYCLES
// consecutive clocks; any return to the clean level restarts the count.
//
// Ports
//   clk    : system clock
//   reset  : asynchronous active-low reset
//   raw    : asynchronous input pin
//   clean  : debounced level (registered)
//   rise   : one-cycle pulse on the edge clean goes 0->1 (registered)
//   fall   : one-cycle pulse on the edge clean goes 1->0 (registered)
// -----------------------------------------------------------------------------
module debounce_channel
   import gpio_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);

   localparam int CW = debounce_cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync1_r;
   logic          sync2_r;
   logic [CW-1:0] cnt_r;
   logic          clean_r;
   logic          rise_r;
   logic          fall_r;

   // Synchronizer, stability counter, clean level and edge pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         cnt_r   <= CNT_ZERO;
         clean_r <= 1'b0;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
      end else begin
         sync1_r <= raw;
         sync2_r <= sync1_r;
         rise_r  <= 1'b0;
         fall_r  <= 1'b0;
         if (sync2_r == clean_r) begin
            cnt_r <= CNT_ZERO;
         end else if (cnt_r == CNT_MAX) begin
            // Acceptance: pulses fire on the same edge that clean moves.
            clean_r <= sync2_r;
            cnt_r   <= CNT_ZERO;
            rise_r  <= sync2_r;
            fall_r  <= ~sync2_r;
         end else begin
            cnt_r <= cnt_r + CNT_ONE;
         end
      end
   end

   assign clean = clean_r;
   assign rise  = rise_r;
   assign fall  = fall_r;

endmodule

// File: rtl/gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// gpio_input_conditioner
// Synchronizes and debounces the board push buttons and slide switches before
// they reach the GPIO memory. Buttons additionally get one-cycle press and
// release pulses plus sticky press flags that the bus clears with a
// write-one-to-clear strobe.
//
// Ports
//   clk            : system clock (shared with cores, bus and GPIO memory)
//   reset          : asynchronous active-low reset
//   buttons_raw    : raw button pins
//   switches_raw   : raw switch pins
//   buttons_clean  : debounced button levels
//   switches_clean : debounced switch levels
//   button_press   : one-cycle pulse per accepted 0->1 button transition
//   button_release : one-cycle pulse per accepted 1->0 button transition
//   press_latched  : sticky press flags
//   clear_strobe   : one-cycle clear request from the bus
//   clear_mask     : per-bit clear mask, honoured only with clear_strobe
//   any_press      : OR of press_latched (registered)
// -----------------------------------------------------------------------------
module gpio_input_conditioner
   import gpio_pkg::*;
#(
   parameter int NUM_BUTTONS     = NUM_BUTTONS_DEF,
   parameter int NUM_SWITCHES    = NUM_SWITCHES_DEF,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [NUM_BUTTONS-1:0]  buttons_raw,
   input  logic [NUM_SWITCHES-1:0] switches_raw,
   output logic [NUM_BUTTONS-1:0]  buttons_clean,
   output logic [NUM_SWITCHES-1:0] switches_clean,
   output logic [NUM_BUTTONS-1:0]  button_press,
   output logic [NUM_BUTTONS-1:0]  button_release,
   output logic [NUM_BUTTONS-1:0]  press_latched,
   input  logic                    clear_strobe,
   input  logic [NUM_BUTTONS-1:0]  clear_mask,
   output logic                    any_press
);

   localparam int NCH = NUM_BUTTONS + NUM_SWITCHES;

   logic [NCH-1:0]         raw_s;
   logic [NCH-1:0]         clean_s;
   logic [NCH-1:0]         rise_s;
   logic [NCH-1:0]         fall_s;
   logic [NUM_BUTTONS-1:0] clr_s;
   logic [NUM_BUTTONS-1:0] latched_next_s;
   logic [NUM_BUTTONS-1:0] latched_r;
   logic                   any_r;
   logic                   sw_pulse_unused_s;

   // Buttons occupy the low channel indices, switches the high ones.
   assign raw_s = {switches_raw, buttons_raw};

   genvar gi;
   generate
      for (gi = 0; gi < NCH; gi++) begin : g_ch
         debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
         ) u_ch (
            .clk   (clk),
            .reset (reset),
            .raw   (raw_s[gi]),
            .clean (clean_s[gi]),
            .rise  (rise_s[gi]),
            .fall  (fall_s[gi])
         );
      end
   endgenerate

   assign buttons_clean  = clean_s[NUM_BUTTONS-1:0];
   assign switches_clean = clean_s[NCH-1:NUM_BUTTONS];
   assign button_press   = rise_s[NUM_BUTTONS-1:0];
   assign button_release = fall_s[NUM_BUTTONS-1:0];

   // Switch channels carry no pulse logic; their edge outputs are sunk here.
   assign sw_pulse_unused_s = ^{rise_s[NCH-1:NUM_BUTTONS], fall_s[NCH-1:NUM_BUTTONS]};

   // Next-state sticky flags: set is ORed in after the clear so a press never gets lost.
   always_comb begin
      clr_s          = {NUM_BUTTONS{1'b0}};
      latched_next_s = {NUM_BUTTONS{1'b0}};
      if (clear_strobe) begin
         clr_s = clear_mask;
      end else begin
         clr_s = {NUM_BUTTONS{1'b0}};
      end
      latched_next_s = (latched_r & ~clr_s) | button_press;
   end

   // Sticky flag register and its registered summary bit.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         latched_r <= {NUM_BUTTONS{1'b0}};
         any_r     <= 1'b0;
      end else begin
         latched_r <= latched_next_s;
         any_r     <= |latched_next_s;
      end
   end

   assign press_latched = latched_r;
   assign any_press     = any_r;

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_gpio_input_conditioner
// Directed bench for gpio_input_conditioner with DEBOUNCE_CYCLES=4.
// Inputs change #1 after a rising edge; outputs are sampled #1 after an edge.
// -----------------------------------------------------------------------------
module tb_gpio_input_conditioner;

   localparam int NB = 4;
   localparam int NS = 16;
   localparam int DC = 4;

   logic          clk;
   logic          reset;
   logic [NB-1:0] buttons_raw;
   logic [NS-1:0] switches_raw;
   logic [NB-1:0] buttons_clean;
   logic [NS-1:0] switches_clean;
   logic [NB-1:0] button_press;
   logic [NB-1:0] button_release;
   logic [NB-1:0] press_latched;
   logic          clear_strobe;
   logic [NB-1:0] clear_mask;
   logic          any_press;

   int n_cmp;
   int n_err;

   gpio_input_conditioner #(
      .NUM_BUTTONS     (NB),
      .NUM_SWITCHES    (NS),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .buttons_raw    (buttons_raw),
      .switches_raw   (switches_raw),
      .buttons_clean  (buttons_clean),
      .switches_clean (switches_clean),
      .button_press   (button_press),
      .button_release (button_release),
      .press_latched  (press_latched),
      .clear_strobe   (clear_strobe),
      .clear_mask     (clear_mask),
      .any_press      (any_press)
   );

   // Free-running 10 ns clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Directed scenario sequence.
   initial begin
      logic [2:0] seen_btn;
      logic       seen_sw;
      n_cmp = 0;
      n_err = 0;
      reset        = 1'b0;
      buttons_raw  = 4'hF;
      switches_raw = 16'hFFFF;
      clear_strobe = 1'b0;
      clear_mask   = 4'h0;
      #1;

      // 1. Reset held with all inputs high: everything stays 0.
      for (int k = 0; k < 3; k++) begin
         step(1);
         check_val("rst_btn", {16'h0, buttons_clean, button_press, button_release, press_latched}, 32'h0);
         check_val("rst_sw", {16'h0, switches_clean}, 32'h0);
         check_val("rst_any", {31'h0, any_press}, 32'h0);
      end
      reset = 1'b1;
      step(5);
      check_val("pwr_pre_btn", {28'h0, buttons_clean}, 32'h0);
      step(1);
      check_val("pwr_btn", {28'h0, buttons_clean}, 32'hF);
      check_val("pwr_sw", {16'h0, switches_clean}, 32'hFFFF);
      check_val("pwr_press", {28'h0, button_press}, 32'hF);
      step(1);
      check_val("pwr_press_end", {28'h0, button_press}, 32'h0);
      check_val("pwr_latched", {28'h0, press_latched}, 32'hF);
      check_val("pwr_any", {31'h0, any_press}, 32'h1);
      clear_strobe = 1'b1;
      clear_mask   = 4'hF;
      step(1);
      clear_strobe = 1'b0;
      clear_mask   = 4'h0;
      check_val("boot_clr", {28'h0, press_latched}, 32'h0);
      check_val("boot_clr_any", {31'h0, any_press}, 32'h0);
      buttons_raw  = 4'h0;
      switches_raw = 16'h0;
      step(6);
      check_val("pwr_release", {28'h0, button_release}, 32'hF);
      check_val("pwr_sw_low", {16'h0, switches_clean}, 32'h0);
      check_val("rel_no_latch", {28'h0, press_latched}, 32'h0);
      step(1);
      check_val("pwr_release_end", {28'h0, button_release}, 32'h0);

      // 2. Clean press then release on button 0.
      buttons_raw = 4'h1;
      step(5);
      check_val("p_pre", {28'h0, buttons_clean}, 32'h0);
      step(1);
      check_val("p_clean", {28'h0, buttons_clean}, 32'h1);
      check_val("p_press", {28'h0, button_press}, 32'h1);
      step(1);
      check_val("p_press_end", {28'h0, button_press}, 32'h0);
      check_val("p_latched", {28'h0, press_latched}, 32'h1);
      check_val("p_any", {31'h0, any_press}, 32'h1);
      buttons_raw = 4'h0;
      step(5);
      check_val("r_pre", {28'h0, button_release}, 32'h0);
      step(1);
      check_val("r_release", {28'h0, button_release}, 32'h1);
      check_val("r_clean", {28'h0, buttons_clean}, 32'h0);
      step(1);
      check_val("r_latched_kept", {28'h0, press_latched}, 32'h1);

      // 3. Bounce on button 1 and a short switch pulse are rejected.
      seen_btn = 3'b000;
      for (int k = 0; k < 4; k++) begin
         buttons_raw[1] = (k % 2 == 0);
         for (int j = 0; j < 2; j++) begin
            step(1);
            seen_btn |= {buttons_clean[1], button_press[1], press_latched[1]};
         end
      end
      for (int j = 0; j < 8; j++) begin
         step(1);
         seen_btn |= {buttons_clean[1], button_press[1], press_latched[1]};
      end
      check_val("bounce_btn1", {29'h0, seen_btn}, 32'h0);
      seen_sw = 1'b0;
      switches_raw[5] = 1'b1;
      for (int j = 0; j < 3; j++) begin
         step(1);
         seen_sw |= switches_clean[5];
      end
      switches_raw[5] = 1'b0;
      for (int j = 0; j < 8; j++) begin
         step(1);
         seen_sw |= switches_clean[5];
      end
      check_val("glitch_sw5", {31'h0, seen_sw}, 32'h0);

      // 4. Write-one-to-clear behaviour.
      buttons_raw = 4'h4;
      step(7);
      check_val("c_setup", {28'h0, press_latched}, 32'h5);
      buttons_raw = 4'h0;
      step(7);
      clear_strobe = 1'b1;
      clear_mask   = 4'h1;
      step(1);
      clear_strobe = 1'b0;
      check_val("c_bit0", {28'h0, press_latched}, 32'h4);
      clear_mask = 4'h4;
      step(2);
      check_val("c_no_strobe", {28'h0, press_latched}, 32'h4);
      check_val("c_no_strobe_any", {31'h0, any_press}, 32'h1);
      clear_strobe = 1'b1;
      step(1);
      clear_strobe = 1'b0;
      clear_mask   = 4'h0;
      check_val("c_bit2", {28'h0, press_latched}, 32'h0);
      check_val("c_any", {31'h0, any_press}, 32'h0);

      // 5. Clear and set on the same bit in the same cycle: set wins.
      buttons_raw = 4'h4;
      step(6);
      check_val("col_press", {28'h0, button_press}, 32'h4);
      clear_strobe = 1'b1;
      clear_mask   = 4'h4;
      step(1);
      clear_strobe = 1'b0;
      clear_mask   = 4'h0;
      check_val("col_latched", {28'h0, press_latched}, 32'h4);
      check_val("col_any", {31'h0, any_press}, 32'h1);
      buttons_raw = 4'h0;
      step(7);

      // 6. Asynchronous reset in the middle of a switch debounce.
      switches_raw[15] = 1'b1;
      step(4);
      reset = 1'b0;
      #1;
      check_val("mid_rst_sw", {16'h0, switches_clean}, 32'h0);
      check_val("mid_rst_latched", {28'h0, press_latched}, 32'h0);
      step(2);
      check_val("mid_rst_hold", {16'h0, switches_clean}, 32'h0);
      reset = 1'b1;
      step(5);
      check_val("mid_rst_pre", {16'h0, switches_clean}, 32'h0);
      step(1);
      check_val("mid_rst_rise", {16'h0, switches_clean}, 32'h8000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
